// File: rtl/req_arb_pkg.sv
// rtl/req_arb_pkg.sv - shared types and defaults for the round-robin request arbiter
package req_arb_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - circular first-set-bit search over the request vector starting at ptr
module rr_pick
  import req_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] win_id
);

  // Scan ptr, ptr+1, ... wrapping at N; the first hit wins.
  always_comb begin
    logic [IDW:0]   v_sum;
    logic [IDW-1:0] v_idx;
    found  = 1'b0;
    win_id = '0;
    v_sum  = '0;
    v_idx  = '0;
    for (int k = 0; k < N; k++) begin
      v_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (v_sum >= (IDW+1)'(N)) begin
        v_sum = v_sum - (IDW+1)'(N);
      end
      v_idx = v_sum[IDW-1:0];
      if (!found && req[v_idx]) begin
        found  = 1'b1;
        win_id = v_idx;
      end
    end
  end

endmodule

// File: rtl/req_rr_arbiter.sv
// rtl/req_rr_arbiter.sv - round-robin arbiter with hold limit and one-cycle gap between grants
module req_rr_arbiter
  import req_arb_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  localparam int HW = $clog2(MAX_HOLD);

  arb_state_t     r_state;
  logic [N-1:0]   r_grant;
  logic [IDW-1:0] r_grant_id;
  logic           r_busy;
  logic           r_timeout;
  logic [IDW-1:0] r_ptr;
  logic [HW-1:0]  r_hold;

  arb_state_t     w_state_nxt;
  logic [N-1:0]   w_grant_nxt;
  logic [IDW-1:0] w_grant_id_nxt;
  logic           w_timeout_nxt;
  logic [IDW-1:0] w_ptr_nxt;
  logic [HW-1:0]  w_hold_nxt;
  logic           w_found;
  logic [IDW-1:0] w_win_id;
  logic [IDW-1:0] w_ptr_after;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .found  (w_found),
    .win_id (w_win_id)
  );

  // The grantee moves to the back of the rotation once its tenure ends.
  assign w_ptr_after = (r_grant_id == IDW'(N-1)) ? '0 : r_grant_id + 1'b1;

  // Next state and next registered outputs; IDLE and RELEASE arbitrate identically.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = '0;
    w_grant_id_nxt = r_grant_id;
    w_timeout_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_hold_nxt     = r_hold;
    case (r_state)
      GRANT: begin
        if (!req[r_grant_id]) begin
          w_state_nxt = RELEASE;
          w_ptr_nxt   = w_ptr_after;
        end else if (r_hold == HW'(MAX_HOLD-1)) begin
          w_state_nxt   = RELEASE;
          w_ptr_nxt     = w_ptr_after;
          w_timeout_nxt = 1'b1;
        end else begin
          w_grant_nxt = r_grant;
          w_hold_nxt  = r_hold + 1'b1;
        end
      end
      default: begin
        if (w_found) begin
          w_state_nxt           = GRANT;
          w_grant_nxt[w_win_id] = 1'b1;
          w_grant_id_nxt        = w_win_id;
          w_hold_nxt            = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset clears everything at once, even mid-tenure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= |w_grant_nxt;
      r_timeout  <= w_timeout_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;
  assign timeout  = r_timeout;

endmodule
